// File: rtl/exu_pkg.sv
// Shared encodings for the NPC execute stage: instruction kinds, branch conditions,
// ALU control codes and the output-slot state type.
package exu_pkg;

   localparam logic [1:0] KIND_ALU    = 2'd0;
   localparam logic [1:0] KIND_BRANCH = 2'd1;
   localparam logic [1:0] KIND_JAL    = 2'd2;
   localparam logic [1:0] KIND_JALR   = 2'd3;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } slotState_e;

endpackage

// File: rtl/alu.sv
// Integer ALU of the NPC core. On subtract, carryFlag is the borrow (a < b unsigned).
module alu
   import exu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zeroFlag,
   output logic             carryFlag,
   output logic             overflowFlag
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   shamt;

   assign shamt = b[SHW-1:0];

   // NOTE: every output of a combinational block gets a default before the case, so no path infers a latch.
   always_comb begin
      sum          = '0;
      result       = '0;
      carryFlag    = 1'b0;
      overflowFlag = 1'b0;
      case (ctrl)
         ALU_ADD: begin
            sum          = {1'b0, a} + {1'b0, b};
            result       = sum[WIDTH-1:0];
            carryFlag    = sum[WIDTH];
            overflowFlag = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            sum          = {1'b0, a} - {1'b0, b};
            result       = sum[WIDTH-1:0];
            carryFlag    = sum[WIDTH];
            overflowFlag = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SLL:   result = a << shamt;
         ALU_SLT:   result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU:  result = {{(WIDTH-1){1'b0}}, a < b};
         ALU_XOR:   result = a ^ b;
         ALU_SRL:   result = a >> shamt;
         ALU_SRA:   result = $signed(a) >>> shamt;
         ALU_OR:    result = a | b;
         ALU_AND:   result = a & b;
         ALU_PASSB: result = b;
         default:   result = '0;
      endcase
      zeroFlag = (result == '0);
   end

endmodule

// File: rtl/exu_branch_cmp.sv
// Branch condition evaluation from the flags of an ALU subtract of rs1 - rs2.
module exu_branch_cmp
   import exu_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       zeroFlag,
   input  logic       carryFlag,
   input  logic       overflowFlag,
   input  logic       signBit,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         BEQ:     taken = zeroFlag;
         BNE:     taken = !zeroFlag;
         BLT:     taken = signBit ^ overflowFlag;
         BGE:     taken = !(signBit ^ overflowFlag);
         BLTU:    taken = carryFlag;
         BGEU:    taken = !carryFlag;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/exu_stage.sv
// Execute stage: operand select, ALU, branch/jump resolution and a registered output slot.
// Optional EXU_SKID_EN adds a skid entry so in_ready becomes a register.
module exu_stage
   import exu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CTL_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_pc,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [WIDTH-1:0] in_src2,
   input  logic [WIDTH-1:0] in_imm,
   input  logic [3:0]       in_alu_ctrl,
   input  logic             in_a_sel,
   input  logic             in_b_sel,
   input  logic [1:0]       in_kind,
   input  logic [2:0]       in_funct3,
   input  logic [4:0]       in_rd,
   input  logic             in_wen,
   input  logic [CTL_W-1:0] in_ctl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [WIDTH-1:0] out_store,
   output logic [4:0]       out_rd,
   output logic             out_wen,
   output logic [CTL_W-1:0] out_ctl,
   output logic             redirect_valid,
   output logic [WIDTH-1:0] redirect_pc
);

   typedef struct packed {
      logic [WIDTH-1:0] result;
      logic [WIDTH-1:0] store;
      logic [WIDTH-1:0] target;
      logic [4:0]       rd;
      logic             wen;
      logic [CTL_W-1:0] ctl;
   } entry_t;

   logic [WIDTH-1:0] aluA, aluB, aluResult, targetSum;
   logic             zeroFlag, carryFlag, overflowFlag, taken;
   logic             isJump, doRedirect, accept, loadIn, skidValid, redirectValid;
   entry_t           incoming, slot;
   slotState_e       state, stateNext;

   assign aluA = in_a_sel ? in_pc  : in_src1;
   assign aluB = in_b_sel ? in_imm : in_src2;

   alu #(.WIDTH(WIDTH)) uAlu (
      .ctrl         (in_alu_ctrl),
      .a            (aluA),
      .b            (aluB),
      .result       (aluResult),
      .zeroFlag     (zeroFlag),
      .carryFlag    (carryFlag),
      .overflowFlag (overflowFlag)
   );

   exu_branch_cmp uBranchCmp (
      .funct3       (in_funct3),
      .zeroFlag     (zeroFlag),
      .carryFlag    (carryFlag),
      .overflowFlag (overflowFlag),
      .signBit      (aluResult[WIDTH-1]),
      .taken        (taken)
   );

   assign isJump     = (in_kind == KIND_JAL) || (in_kind == KIND_JALR);
   assign doRedirect = isJump || ((in_kind == KIND_BRANCH) && taken);
   // Target adder is independent of the ALU so the ALU stays free for the branch compare.
   assign targetSum  = ((in_kind == KIND_JALR) ? in_src1 : in_pc) + in_imm;

   always_comb begin
      incoming        = '0;
      incoming.result = isJump ? in_pc + WIDTH'(4) : aluResult;
      incoming.store  = in_src2;
      incoming.target = (in_kind == KIND_JALR) ? (targetSum & ~WIDTH'(1)) : targetSum;
      incoming.rd     = in_rd;
      incoming.wen    = in_wen;
      incoming.ctl    = in_ctl;
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      stateNext = state;
      case (state)
         EMPTY:   if (accept) stateNext = FULL;
         FULL:    if (out_ready && !accept && !skidValid) stateNext = EMPTY;
         default: stateNext = EMPTY;
      endcase
   end

`ifdef EXU_SKID_EN
   logic   drain, toSkid, skidRedir, inReadyQ;
   entry_t skid;

   assign drain    = (state == FULL) && out_ready;
   assign toSkid   = accept && (state == FULL) && !out_ready;
   assign loadIn   = accept && !toSkid;
   assign in_ready = inReadyQ;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skidValid <= 1'b0;
         inReadyQ  <= 1'b1;
      end else begin
         if (toSkid)     skidValid <= 1'b1;
         else if (drain) skidValid <= 1'b0;
         inReadyQ <= !(toSkid || (skidValid && !drain));
      end
   end

   // NOTE: skid storage is qualified by skidValid, so its data needs no reset.
   always_ff @(posedge clk) begin
      if (toSkid) begin
         skid      <= incoming;
         skidRedir <= doRedirect;
      end
   end
`else
   assign skidValid = 1'b0;
   assign loadIn    = accept;
   assign in_ready  = (state == EMPTY) || out_ready;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= EMPTY;
         slot          <= '0;
         redirectValid <= 1'b0;
      end else begin
         state         <= stateNext;
         redirectValid <= 1'b0;
         if (loadIn) begin
            slot          <= incoming;
            redirectValid <= doRedirect;
         end
`ifdef EXU_SKID_EN
         else if (skidValid && drain) begin
            slot          <= skid;
            redirectValid <= skidRedir;
         end
`endif
      end
   end

   assign out_valid      = (state == FULL);
   assign out_result     = slot.result;
   assign out_store      = slot.store;
   assign out_rd         = slot.rd;
   assign out_wen        = slot.wen;
   assign out_ctl        = slot.ctl;
   assign redirect_valid = redirectValid;
   assign redirect_pc    = slot.target;

endmodule

// File: tb/tb_exu_stage.sv
// Self-checking bench for exu_stage: directed cases plus randomized traffic against a queue model.
module tb_exu_stage;
   import exu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_a_sel, in_b_sel, in_wen;
   logic [31:0] in_pc, in_src1, in_src2, in_imm;
   logic [3:0]  in_alu_ctrl;
   logic [1:0]  in_kind;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic [7:0]  in_ctl;
   logic        out_valid, out_ready, out_wen, redirect_valid;
   logic [31:0] out_result, out_store, redirect_pc;
   logic [4:0]  out_rd;
   logic [7:0]  out_ctl;

   exu_stage #(.WIDTH(32), .CTL_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
      .in_alu_ctrl(in_alu_ctrl), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
      .in_kind(in_kind), .in_funct3(in_funct3), .in_rd(in_rd),
      .in_wen(in_wen), .in_ctl(in_ctl),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_store(out_store), .out_rd(out_rd), .out_wen(out_wen), .out_ctl(out_ctl),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] result;
      logic [31:0] store;
      logic [31:0] target;
      logic [4:0]  rd;
      logic        wen;
      logic [7:0]  ctl;
      logic        redir;
   } exp_t;

   exp_t q[$];
   bit   headNew;
   int   nCompared   = 0;
   int   nMismatched = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         ALU_ADD:   return a + b;
         ALU_SUB:   return a - b;
         ALU_SLL:   return a << b[4:0];
         ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:   return a ^ b;
         ALU_SRL:   return a >> b[4:0];
         ALU_SRA:   return $signed(a) >>> b[4:0];
         ALU_OR:    return a | b;
         ALU_AND:   return a & b;
         ALU_PASSB: return b;
         default:   return 32'd0;
      endcase
   endfunction

   function automatic bit refTaken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      case (f3)
         BEQ:     return a == b;
         BNE:     return a != b;
         BLT:     return $signed(a) <  $signed(b);
         BGE:     return $signed(a) >= $signed(b);
         BLTU:    return a <  b;
         BGEU:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic checkOutputs();
      bit expRedir;
      expRedir = (q.size() > 0) && headNew && q[0].redir;
      check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
      check("redirect_valid", {31'd0, redirect_valid}, {31'd0, expRedir});
      if (q.size() > 0) begin
         check("out_result", out_result, q[0].result);
         check("out_store", out_store, q[0].store);
         check("out_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
         check("out_wen", {31'd0, out_wen}, {31'd0, q[0].wen});
         check("out_ctl", {24'd0, out_ctl}, {24'd0, q[0].ctl});
      end
      if (expRedir) check("redirect_pc", redirect_pc, q[0].target);
   endtask

   // Called at posedge+1; drives one cycle of inputs, checks in_ready, then checks the slot after the edge.
   task automatic runCycle(input bit v, input logic [31:0] pc, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] imm, input logic [3:0] ctrl,
                           input bit aSel, input bit bSel, input logic [1:0] kind,
                           input logic [2:0] f3, input logic [4:0] rd, input bit wen,
                           input logic [7:0] ctl, input bit ready);
      exp_t        e;
      logic [31:0] opA, opB;
      bit          expReady, acc, drn, jump, newHead;
      in_valid = v;  in_pc = pc;  in_src1 = s1;  in_src2 = s2;  in_imm = imm;
      in_alu_ctrl = ctrl;  in_a_sel = aSel;  in_b_sel = bSel;  in_kind = kind;
      in_funct3 = f3;  in_rd = rd;  in_wen = wen;  in_ctl = ctl;  out_ready = ready;
      #1;
`ifdef EXU_SKID_EN
      expReady = q.size() < 2;
`else
      expReady = (q.size() == 0) || ready;
`endif
      check("in_ready", {31'd0, in_ready}, {31'd0, expReady});
      opA      = aSel ? pc : s1;
      opB      = bSel ? imm : s2;
      jump     = (kind == KIND_JAL) || (kind == KIND_JALR);
      e.result = jump ? pc + 32'd4 : refAlu(ctrl, opA, opB);
      e.store  = s2;
      e.target = (kind == KIND_JALR) ? ((s1 + imm) & 32'hFFFF_FFFE) : pc + imm;
      e.rd     = rd;
      e.wen    = wen;
      e.ctl    = ctl;
      e.redir  = jump || ((kind == KIND_BRANCH) && refTaken(f3, opA, opB));
      acc      = v && expReady;
      drn      = (q.size() > 0) && ready;
      newHead  = ((q.size() == 0) && acc) || (drn && ((q.size() > 1) || acc));
      @(posedge clk);
      #1;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
      headNew = newHead;
      checkOutputs();
   endtask

   task automatic idle(input bit ready);
      runCycle(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, KIND_ALU, 3'd0, 5'd0, 1'b0, 8'd0, ready);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;  in_pc = '0;  in_src1 = '0;  in_src2 = '0;  in_imm = '0;
      in_alu_ctrl = '0;  in_a_sel = 1'b0;  in_b_sel = 1'b0;  in_kind = '0;
      in_funct3 = '0;  in_rd = '0;  in_wen = 1'b0;  in_ctl = '0;  out_ready = 1'b0;
      headNew = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      check("rst_out_wen", {31'd0, out_wen}, 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_store", out_store, 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      check("rst_out_rd", {27'd0, out_rd}, 32'd0);
      check("rst_out_ctl", {24'd0, out_ctl}, 32'd0);
      rst = 1'b0;

      // ADD 5+7
      runCycle(1'b1, 32'h100, 32'd5, 32'd7, 32'd0, ALU_ADD, 1'b0, 1'b0, KIND_ALU, 3'd0, 5'd3, 1'b1, 8'h5A, 1'b1);
      check("add_result", out_result, 32'd12);
      idle(1'b1);

      // BEQ taken, then BNE with the same operands not taken
      runCycle(1'b1, 32'h8000_0010, 32'd3, 32'd3, 32'h20, ALU_SUB, 1'b0, 1'b0, KIND_BRANCH, BEQ, 5'd0, 1'b0, 8'h00, 1'b1);
      check("beq_redirect_pc", redirect_pc, 32'h8000_0030);
      check("beq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      runCycle(1'b1, 32'h8000_0010, 32'd3, 32'd3, 32'h20, ALU_SUB, 1'b0, 1'b0, KIND_BRANCH, BNE, 5'd0, 1'b0, 8'h00, 1'b1);
      check("bne_redirect_valid", {31'd0, redirect_valid}, 32'd0);

      // BLTU not taken, BLT taken on 0xFFFFFFFF vs 1
      runCycle(1'b1, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, ALU_SUB, 1'b0, 1'b0, KIND_BRANCH, BLTU, 5'd0, 1'b0, 8'h00, 1'b1);
      check("bltu_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      runCycle(1'b1, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, ALU_SUB, 1'b0, 1'b0, KIND_BRANCH, BLT, 5'd0, 1'b0, 8'h00, 1'b1);
      check("blt_redirect_valid", {31'd0, redirect_valid}, 32'd1);
      check("blt_redirect_pc", redirect_pc, 32'h240);

      // JALR clears bit 0 of the target and writes pc+4
      runCycle(1'b1, 32'h8000_0000, 32'h8000_0101, 32'd0, 32'd4, ALU_ADD, 1'b0, 1'b1, KIND_JALR, 3'd0, 5'd1, 1'b1, 8'h00, 1'b1);
      check("jalr_redirect_pc", redirect_pc, 32'h8000_0104);
      check("jalr_result", out_result, 32'h8000_0004);
      idle(1'b1);

      // Stall three cycles behind a taken branch, then drain
      runCycle(1'b1, 32'h300, 32'd9, 32'd9, 32'h10, ALU_SUB, 1'b0, 1'b0, KIND_BRANCH, BEQ, 5'd0, 1'b0, 8'h11, 1'b1);
      for (int i = 0; i < 3; i++)
         runCycle(1'b1, 32'h304 + 32'(4 * i), 32'(i), 32'd100, 32'd0, ALU_ADD, 1'b0, 1'b0, KIND_ALU, 3'd0, 5'(i + 4), 1'b1, 8'(i), 1'b0);
      check("stall_result_held", out_result, 32'd0);
      for (int i = 0; i < 3; i++) idle(1'b1);

      // JAL accepted into a stalled slot, then async reset mid-stall
      runCycle(1'b1, 32'h400, 32'd0, 32'd0, 32'h80, ALU_ADD, 1'b0, 1'b0, KIND_JAL, 3'd0, 5'd1, 1'b1, 8'h22, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      headNew = 1'b0;
      idle(1'b0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [1:0]  kind;
         logic [3:0]  ctrl;
         logic [2:0]  f3;
         logic [31:0] s1, s2;
         bit          aSel, bSel;
         kind = 2'($urandom_range(0, 3));
         f3   = 3'($urandom_range(0, 7));
         s1   = $urandom;
         s2   = ($urandom_range(0, 3) == 0) ? s1 : $urandom;
         if (kind == KIND_BRANCH) begin
            ctrl = ALU_SUB;  aSel = 1'b0;  bSel = 1'b0;
         end else begin
            ctrl = 4'($urandom_range(0, 10));
            aSel = 1'($urandom_range(0, 1));
            bSel = 1'($urandom_range(0, 1));
         end
         runCycle($urandom_range(0, 3) != 0, $urandom, s1, s2, $urandom, ctrl, aSel, bSel, kind, f3,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 3; i++) idle(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/exu_stage.md
# exu_stage

Execute stage of the NPC core. Accepts one decoded instruction per handshake from the decode stage and selects the ALU operands. Instantiates the ALU and resolves branches and jumps from the ALU result and flags. Registers the result, destination, and pass-through control into an output slot that the memory/writeback stage drains with a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32, datapath width
- CTL_W, 8, width of opaque downstream control (mem op, size, sign) passed through untouched

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  decode has an instruction
- in_ready  output  1  stage can accept this cycle
- in_pc  input  WIDTH  instruction address
- in_src1, in_src2  input  WIDTH  rs1/rs2 values
- in_imm  input  WIDTH  sign-extended immediate
- in_alu_ctrl  input  4  ALU control code, forwarded to ALU ctrl
- in_a_sel  input  1  0: src1, 1: pc → ALU input1
- in_b_sel  input  1  0: src2, 1: imm → ALU input2
- in_kind  input  2  0 ALU, 1 BRANCH, 2 JAL, 3 JALR
- in_funct3  input  3  branch condition (RV32 encoding)
- in_rd  input  5  destination register
- in_wen  input  1  register write enable
- in_ctl  input  CTL_W  pass-through control
- out_valid  output  1  output slot holds an instruction
- out_ready  input  1  downstream accepts
- out_result  output  WIDTH  ALU result, or pc+4 for JAL/JALR
- out_store  output  WIDTH  src2 (store data)
- out_rd, out_wen, out_ctl  output  5/1/CTL_W  registered pass-through
- redirect_valid  output  1  one-cycle pulse: taken branch or jump
- redirect_pc  output  WIDTH  redirect target

## Operation
- Accept when in_valid && in_ready at a rising edge. Operands, ALU, and branch compare are evaluated combinationally in the accept cycle. Results are registered.
- Branch decision uses ALU flags with in_alu_ctrl = subtract:
  - beq: zero_flag. bne: !zero_flag.
  - blt: result[WIDTH-1]^overflow_flag. bge: the inverse.
  - bltu: carry_flag, defined as borrow (1 when src1 < src2 unsigned). bgeu: the inverse.
  - funct3 010/011 → not taken.
- Targets come from a dedicated adder, not the ALU:
  - BRANCH/JAL: pc+imm.
  - JALR: (src1+imm) & ~1.
- Output result: JAL/JALR write pc+4. ALU and BRANCH write the ALU result.
- Output FSM with states EMPTY and FULL:
  - EMPTY→FULL on accept.
  - FULL→EMPTY on out_ready with no accept.
  - FULL→FULL on simultaneous drain and accept, with the slot replaced.
- in_ready = !out_valid || out_ready.
- redirect_valid asserts for exactly the first cycle an instruction occupies the slot, if taken or jump. It does not re-assert while the slot stalls. A pending-redirect flag clears after one cycle.
- Reset mid-stall discards the slot, with no redirect and no output.
- Reset values: out_valid 0, redirect_valid 0, out_wen 0, out_result/out_store/redirect_pc 0, out_rd 0, out_ctl 0, FSM EMPTY.

## Timing
- Latency 1: accept at edge T → out_valid and redirect_valid from T+1.
- Throughput: 1 instruction/cycle when out_ready is held high.
- out_* are stable while out_valid && !out_ready.
- in_ready is combinational from out_ready (without the configuration macro).
- redirect_pc is valid only while redirect_valid.

## Configuration
- EXU_SKID_EN defined:
  - Adds a second skid entry, and in_ready becomes a register: high when the skid entry is empty.
  - An accept during a stall lands in the skid entry and moves to the slot on the next drain. redirect for it pulses on that move.
  - Latency still 1 when unstalled. Full throughput is kept.
- EXU_SKID_EN undefined: single slot, combinational in_ready as above.

## Structure
- Shared package exu_pkg holds:
  - kind encodings: KIND_ALU, KIND_BRANCH, KIND_JAL, KIND_JALR
  - branch funct3 constants: BEQ, BNE, BLT, BGE, BLTU, BGEU
  - the ALU subtract control code
  - the FSM state typedef
- Sub-module exu_branch_cmp: combinational. Takes funct3 and ALU flags/result sign and produces taken.
- The ALU is instantiated unchanged. The output slot and skid logic live in exu_stage.

## Test plan
- ADD: src1=5, src2=7, out_ready=1 → next cycle out_valid=1, out_result=12, redirect_valid=0.
- BEQ with pc=0x80000010, src1=src2=3, imm=0x20 → redirect_valid pulses one cycle, redirect_pc=0x80000030. BNE with the same operands → no pulse.
- BLTU with src1=0xFFFFFFFF, src2=1 → not taken. BLT with the same operands → taken.
- JALR with src1=0x80000101, imm=4, pc=0x80000000 → redirect_pc=0x80000104, out_result=0x80000004.
- Stall: out_ready=0 for 3 cycles after a taken branch → out_* stable, redirect_valid high only the first cycle, in_ready=0 (or a single accept with EXU_SKID_EN). Release → back-to-back drain in order.
- Assert rst while FULL and stalled → out_valid and redirect_valid drop immediately (async). After release the stage is EMPTY with in_ready=1.
